if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the rv32i core. Owns the PC register and issues word fetches to instruction memory over a valid/ready request with a fixed-order response.
- Presents {pc, instr} to decode over a valid/ready handshake.
- Next PC comes from a two_to_1_mux instance selecting pc+4 or redirect_pc. This block is the mux's direct consumer and the producer of its pc+4 input.
- One fetch outstanding at a time; multicycle-friendly, not pipelined.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored (treated as 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address, always word aligned.
- imem_rsp_valid  in  1  response valid; exactly one per accepted request, 1+ cycles after acceptance.
- imem_rdata  in  32  fetched instruction.
- id_valid  out  1  decode-side data valid.
- id_ready  in  1  decode accepts.
- id_pc  out  XLEN  PC of the presented instruction.
- id_instr  out  32  presented instruction.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, rst_n). While rst_n=0 at a rising edge:
  - state<=IDLE, pc<=RESET_PC, drop<=0.
  - id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP).
  - imem_req_valid=0, imem_addr=RESET_PC.
- States: IDLE, REQ, WAIT, HOLD.
  - IDLE -> REQ unconditionally; used only after reset.
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_valid&imem_req_ready: inflight_pc<=pc, pc<=next_pc, ->WAIT.
  - WAIT: on imem_rsp_valid:
    - drop=1: discard, drop<=0, ->REQ.
    - drop=0: id_pc<=inflight_pc, id_instr<=imem_rdata, id_valid<=1, ->HOLD.
  - HOLD: id_valid=1, outputs stable until id_valid&id_ready, then id_valid<=0, ->REQ.
- next_pc = redirect_valid ? {redirect_pc[XLEN-1:2],2'b00} : pc+4, selected by the two_to_1_mux.
- pc+4 wraps modulo 2^XLEN: 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
- Redirect handling (redirect_valid=1, any state except IDLE):
  - pc loads the redirect target next cycle.
  - REQ with a handshake the same cycle: the request is issued at the old pc and marked drop<=1; pc<=target, not target+4.
  - REQ without a handshake: pc<=target only; no request is consumed.
  - WAIT: drop<=1; state stays WAIT until the response arrives.
  - HOLD: id_valid<=0 next cycle (flush) even if id_ready=1 that cycle; the handshake does not count; ->REQ.
  - IDLE: redirect is ignored.
- Latency: redirect to imem_req_valid at the target is 1 cycle if no fetch is in flight. Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD).
- imem_rsp_valid outside WAIT is ignored (protocol error; no state change).
- Reset mid-operation drops any in-flight response. The memory must be reset with the core.
- All outputs are registered or decoded from state only; no combinational in->out path except imem_addr and imem_req_valid, which are state/pc decoded.

Decomposition:
- Shared rv32i_pkg holds:
  - XLEN
  - RV_NOP = 32'h0000_0013
  - PC_STEP = 4
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD}
- Sub-module: existing two_to_1_mux #(.DWIDTH(XLEN)) for next-PC selection (Sel=redirect_valid, input_1=pc+4, input_2=aligned redirect_pc). No other children.

Test Plan:
1. Reset, imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_A5A5, id_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; id_pc/id_instr match; id_valid pulses every 3rd cycle.
2. id_ready=0 for 5 cycles in HOLD -> id_valid stays 1, id_pc/id_instr stable; no new imem request until id_ready=1.
3. redirect_valid=1, redirect_pc=0x0000_0103 while in WAIT -> in-flight response discarded (no id_valid); next imem_addr=0x0000_0100.
4. Redirect in HOLD with id_ready=1 the same cycle -> id_valid=0 next cycle, no handshake counted; next fetch at the target.
5. RESET_PC=32'hFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
6. Assert rst_n=0 during WAIT, then release -> IDLE then REQ at RESET_PC; the stale response is not forwarded; id_instr=0x0000_0013 during reset.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared rv32i core definitions: datapath width, NOP encoding, PC step and fetch FSM states.
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam logic [31:0] RV_NOP  = 32'h0000_0013;
    localparam int unsigned PC_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/two_to_1_mux.sv
// Generic two-input mux: sel=0 passes input_1, sel=1 passes input_2.
module two_to_1_mux #(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              sel,
    input  logic [DWIDTH-1:0] input_1,
    input  logic [DWIDTH-1:0] input_2,
    output logic [DWIDTH-1:0] mux_out
);

    assign mux_out = sel ? input_2 : input_1;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// hands {pc, instr} to decode over valid/ready.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr
);

    import rv32i_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            drop;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] next_pc;
    logic            req_fire;

    assign pc_plus4         = pc + XLEN'(PC_STEP);
    assign redirect_aligned = redirect_pc & ~XLEN'(2'b11);

    two_to_1_mux #(.DWIDTH(XLEN)) u_next_pc_mux (
        .sel     (redirect_valid),
        .input_1 (pc_plus4),
        .input_2 (redirect_aligned),
        .mux_out (next_pc)
    );

    // Request side is a pure decode of registered state and pc.
    assign imem_req_valid = (state == REQ);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight_pc <= RESET_PC;
            drop        <= 1'b0;
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_instr    <= RV_NOP;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                end

                // A redirect coinciding with a handshake still issues the old pc but marks it stale.
                REQ: begin
                    if (req_fire) begin
                        inflight_pc <= pc;
                        pc          <= next_pc;
                        drop        <= redirect_valid;
                        state       <= WAIT;
                    end else if (redirect_valid) begin
                        pc <= next_pc;
                    end
                end

                // A redirect landing together with the response makes that response stale too.
                WAIT: begin
                    if (redirect_valid) begin
                        pc <= next_pc;
                    end
                    if (imem_rsp_valid) begin
                        if (drop || redirect_valid) begin
                            drop  <= 1'b0;
                            state <= REQ;
                        end else begin
                            id_pc    <= inflight_pc;
                            id_instr <= imem_rdata;
                            id_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        drop <= 1'b1;
                    end
                end

                // Redirect flushes the held instruction even if decode accepts it this cycle.
                HOLD: begin
                    if (redirect_valid) begin
                        pc       <= next_pc;
                        id_valid <= 1'b0;
                        state    <= REQ;
                    end else if (id_ready) begin
                        id_valid <= 1'b0;
                        state    <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a behavioural instruction memory.
module tb_if_fetch_stage;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_ready;
    logic        id_ready;

    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    logic        imem_req_valid2;
    logic [31:0] imem_addr2;
    logic        imem_rsp_valid2;
    logic [31:0] imem_rdata2;
    logic        id_valid2;
    logic [31:0] id_pc2;
    logic [31:0] id_instr2;

    int total;
    int bad;

    // Memory model state for the main DUT: response mem_lat cycles after acceptance.
    int          mem_lat;
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rdata     (imem_rdata),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid2),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr2),
        .imem_rsp_valid (imem_rsp_valid2),
        .imem_rdata     (imem_rdata2),
        .id_valid       (id_valid2),
        .id_ready       (id_ready),
        .id_pc          (id_pc2),
        .id_instr       (id_instr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: sample requests before the edge, update memory responses 1ns after it.
    task automatic tick();
        bit          acc;
        bit          acc2;
        logic [31:0] a;
        logic [31:0] a2;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_addr;
        acc2 = imem_req_valid2 && imem_req_ready;
        a2   = imem_addr2;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_data = a ^ XOR_KEY;
        end
        if (pend) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = pend_data;
                pend           = 1'b0;
            end
        end
        imem_rsp_valid2 = acc2;
        imem_rdata2     = acc2 ? (a2 ^ XOR_KEY) : 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
        total++; if (id_pc !== 32'h0) begin bad++; $display("FAIL reset_id_pc got=%h exp=00000000", id_pc); end
        total++; if (id_instr !== NOP) begin bad++; $display("FAIL reset_id_instr got=%h exp=%h", id_instr, NOP); end
        total++; if (imem_addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL reset_addr_wrap got=%h exp=fffffffc", imem_addr2); end
        rst_n = 1'b1;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
        tick();
    endtask

    task automatic test_sequential_fetch();
        logic [31:0] exp_pc;
        for (int n = 0; n < 3; n++) begin
            exp_pc = 32'(n * 4);
            total++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_pc) begin bad++; $display("FAIL seq_req n=%0d got=%b/%h exp=1/%h", n, imem_req_valid, imem_addr, exp_pc); end
            tick();
            total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL seq_wait n=%0d got=%b/%b exp=0/0", n, imem_req_valid, id_valid); end
            tick();
            total++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== (exp_pc ^ XOR_KEY)) begin bad++; $display("FAIL seq_hold n=%0d got=%b/%h/%h exp=1/%h/%h", n, id_valid, id_pc, id_instr, exp_pc, exp_pc ^ XOR_KEY); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        tick();
        id_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if (id_valid !== 1'b1 || id_pc !== 32'hC || id_instr !== (32'hC ^ XOR_KEY) || imem_req_valid !== 1'b0) begin bad++; $display("FAIL hold_stall i=%0d got=%b/%h/%h/%b exp=1/0000000c/%h/0", i, id_valid, id_pc, id_instr, imem_req_valid, 32'hC ^ XOR_KEY); end
            tick();
        end
        id_ready = 1'b1;
        total++; if (id_valid !== 1'b1) begin bad++; $display("FAIL hold_release got=%b exp=1", id_valid); end
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h10 || id_valid !== 1'b0) begin bad++; $display("FAIL hold_next_req got=%b/%h/%b exp=1/00000010/0", imem_req_valid, imem_addr, id_valid); end
    endtask

    task automatic test_redirect_wait();
        mem_lat = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin bad++; $display("FAIL redir_wait_stay got=%b/%b exp=0/0", imem_req_valid, id_valid); end
        tick();
        tick();
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL redir_wait_drop got=%b exp=0", id_valid); end
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin bad++; $display("FAIL redir_wait_target got=%b/%h exp=1/00000100", imem_req_valid, imem_addr); end
        mem_lat = 1;
    endtask

    task automatic test_redirect_hold();
        tick();
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== (32'h100 ^ XOR_KEY)) begin bad++; $display("FAIL redir_hold_pre got=%b/%h/%h exp=1/00000100/%h", id_valid, id_pc, id_instr, 32'h100 ^ XOR_KEY); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        id_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        total++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin bad++; $display("FAIL redir_hold_flush got=%b/%b/%h exp=0/1/00000200", id_valid, imem_req_valid, imem_addr); end
        tick();
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== (32'h200 ^ XOR_KEY)) begin bad++; $display("FAIL redir_hold_fetch got=%b/%h/%h exp=1/00000200/%h", id_valid, id_pc, id_instr, 32'h200 ^ XOR_KEY); end
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h204) begin bad++; $display("FAIL redir_hold_next got=%b/%h exp=1/00000204", imem_req_valid, imem_addr); end
    endtask

    task automatic test_reset_in_wait();
        tick();
        total++; if (imem_req_valid !== 1'b0 || imem_rsp_valid !== 1'b1) begin bad++; $display("FAIL rst_wait_setup got=%b/%b exp=0/1", imem_req_valid, imem_rsp_valid); end
        rst_n = 1'b0;
        tick();
        total++; if (id_valid !== 1'b0 || id_instr !== NOP || imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin bad++; $display("FAIL rst_wait_reset got=%b/%h/%b/%h exp=0/%h/0/00000000", id_valid, id_instr, imem_req_valid, imem_addr, NOP); end
        tick();
        rst_n = 1'b1;
        imem_req_ready = 1'b0;
        total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_idle got=%b exp=0", imem_req_valid); end
        tick();
        tick();
        total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || id_valid !== 1'b0) begin bad++; $display("FAIL rst_wait_req got=%b/%h/%b exp=1/00000000/0", imem_req_valid, imem_addr, id_valid); end
        imem_req_ready = 1'b1;
        tick();
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== XOR_KEY) begin bad++; $display("FAIL rst_wait_fetch got=%b/%h/%h exp=1/00000000/%h", id_valid, id_pc, id_instr, XOR_KEY); end
    endtask

    task automatic test_pc_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        total++; if (imem_req_valid2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_first got=%b/%h exp=1/fffffffc", imem_req_valid2, imem_addr2); end
        tick();
        tick();
        total++; if (id_valid2 !== 1'b1 || id_pc2 !== 32'hFFFF_FFFC || id_instr2 !== 32'h5A5A_5A59) begin bad++; $display("FAIL wrap_hold got=%b/%h/%h exp=1/fffffffc/5a5a5a59", id_valid2, id_pc2, id_instr2); end
        tick();
        total++; if (imem_req_valid2 !== 1'b1 || imem_addr2 !== 32'h0) begin bad++; $display("FAIL wrap_second got=%b/%h exp=1/00000000", imem_req_valid2, imem_addr2); end
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        mem_lat        = 1;
        pend           = 1'b0;
        pend_cnt       = 0;
        pend_data      = 32'h0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        imem_rsp_valid2 = 1'b0;
        imem_rdata2    = 32'h0;
        #1;
        test_reset();
        test_sequential_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_reset_in_wait();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
